// File: rtl/nanci_phase_ctrl.sv
// Phase sequencer for a sqrt(N) x sqrt(N) mesh shear-sort: (ROW,COL) x ROUNDS, then ROW, then COMPUTE.
// Build option NANCI_SNAKE_EN: when defined, o_snake is high during ROW phases.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for i_start, all outputs low
// ROW     | row sort phase, SQRT_N transposition steps
// COL     | column sort phase, SQRT_N transposition steps
// COMPUTE | compute phase, COMPUTE_CYCLES clocks
// DONE    | one-clock completion pulse, then IDLE
module nanci_phase_ctrl #(
    parameter int SQRT_N         = 4,
    parameter int ROUNDS         = 2,
    parameter int SORT_CYCLES    = 1,
    parameter int COMPUTE_CYCLES = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_start,
    input  logic                             i_abort,
    output logic [1:0]                       o_phase,
    output logic                             o_step_en,
    output logic                             o_odd,
    output logic [$clog2(ROUNDS+1)-1:0]      o_round,
    output logic                             o_snake,
    output logic                             o_busy,
    output logic                             o_done
);

    localparam int SW = $clog2(SQRT_N);
    localparam int RW = $clog2(ROUNDS + 1);
    localparam int CW = $clog2(SORT_CYCLES + 1);
    localparam int KW = $clog2(COMPUTE_CYCLES + 1);

    localparam logic [SW-1:0] STEP_LAST  = SW'(SQRT_N - 1);
    localparam logic [RW-1:0] ROUND_LAST = RW'(ROUNDS);
    localparam logic [CW-1:0] CYC_LOAD   = CW'(SORT_CYCLES - 1);
    localparam logic [KW-1:0] COMP_LOAD  = KW'(COMPUTE_CYCLES - 1);

    localparam logic [1:0] PH_IDLE = 2'b00;
    localparam logic [1:0] PH_ROW  = 2'b01;
    localparam logic [1:0] PH_COL  = 2'b10;
    localparam logic [1:0] PH_COMP = 2'b11;

`ifdef NANCI_SNAKE_EN
    localparam logic SNAKE_ROW = 1'b1;
`else
    localparam logic SNAKE_ROW = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, ROW, COL, COMPUTE, DONE} state_t;

    state_t          state_q;
    logic [SW-1:0]   step_q;
    logic [SW-1:0]   step_d;
    logic [CW-1:0]   cyc_q;
    logic [KW-1:0]   comp_q;
    logic [RW-1:0]   round_q;
    logic [1:0]      phase_q;
    logic            step_en_q;
    logic            odd_q;
    logic            snake_q;
    logic            busy_q;
    logic            done_q;

    assign step_d = step_q + SW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            step_q    <= '0;
            cyc_q     <= '0;
            comp_q    <= '0;
            round_q   <= '0;
            phase_q   <= PH_IDLE;
            step_en_q <= 1'b0;
            odd_q     <= 1'b0;
            snake_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            step_en_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start && !i_abort) begin
                        state_q   <= ROW;
                        step_q    <= '0;
                        cyc_q     <= CYC_LOAD;
                        round_q   <= '0;
                        phase_q   <= PH_ROW;
                        step_en_q <= 1'b1;
                        odd_q     <= 1'b0;
                        snake_q   <= SNAKE_ROW;
                        busy_q    <= 1'b1;
                    end
                end
                ROW, COL: begin
                    if (i_abort) begin
                        state_q <= IDLE;
                        step_q  <= '0;
                        cyc_q   <= '0;
                        round_q <= '0;
                        phase_q <= PH_IDLE;
                        odd_q   <= 1'b0;
                        snake_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (cyc_q != '0) begin
                        cyc_q <= cyc_q - CW'(1);
                    end else if (step_q != STEP_LAST) begin
                        step_q    <= step_d;
                        cyc_q     <= CYC_LOAD;
                        step_en_q <= 1'b1;
                        odd_q     <= step_d[0];
                    end else if (state_q == ROW && round_q == ROUND_LAST) begin
                        // final row phase finished: hand over to compute
                        state_q <= COMPUTE;
                        step_q  <= '0;
                        comp_q  <= COMP_LOAD;
                        phase_q <= PH_COMP;
                        odd_q   <= 1'b0;
                        snake_q <= 1'b0;
                    end else if (state_q == ROW) begin
                        state_q   <= COL;
                        step_q    <= '0;
                        cyc_q     <= CYC_LOAD;
                        phase_q   <= PH_COL;
                        step_en_q <= 1'b1;
                        odd_q     <= 1'b0;
                        snake_q   <= 1'b0;
                    end else begin
                        state_q   <= ROW;
                        step_q    <= '0;
                        cyc_q     <= CYC_LOAD;
                        round_q   <= round_q + RW'(1);
                        phase_q   <= PH_ROW;
                        step_en_q <= 1'b1;
                        odd_q     <= 1'b0;
                        snake_q   <= SNAKE_ROW;
                    end
                end
                COMPUTE: begin
                    if (i_abort) begin
                        state_q <= IDLE;
                        comp_q  <= '0;
                        round_q <= '0;
                        phase_q <= PH_IDLE;
                        busy_q  <= 1'b0;
                    end else if (comp_q != '0) begin
                        comp_q <= comp_q - KW'(1);
                    end else begin
                        state_q <= DONE;
                        round_q <= '0;
                        phase_q <= PH_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_phase   = phase_q;
    assign o_step_en = step_en_q;
    assign o_odd     = odd_q;
    assign o_round   = round_q;
    assign o_snake   = snake_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;

endmodule

// File: tb/tb_nanci_phase_ctrl.sv
// Directed bench for nanci_phase_ctrl: per-cycle vector table on a default instance,
// plus a multi-cycle step-timing check on a SORT_CYCLES=3, ROUNDS=1 instance.
module tb_nanci_phase_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, abort;
    logic [1:0] phase;
    logic       step_en, odd, snake, busy, done;
    logic [1:0] round;

    logic       start2;
    logic [1:0] phase2;
    logic       step_en2, odd2, snake2, busy2, done2;
    logic [0:0] round2;

    int checks   = 0;
    int failures = 0;

    nanci_phase_ctrl u_dut (
        .clk(clk), .rst(rst), .i_start(start), .i_abort(abort),
        .o_phase(phase), .o_step_en(step_en), .o_odd(odd), .o_round(round),
        .o_snake(snake), .o_busy(busy), .o_done(done)
    );

    nanci_phase_ctrl #(.SQRT_N(4), .ROUNDS(1), .SORT_CYCLES(3), .COMPUTE_CYCLES(1)) u_dut2 (
        .clk(clk), .rst(rst), .i_start(start2), .i_abort(1'b0),
        .o_phase(phase2), .o_step_en(step_en2), .o_odd(odd2), .o_round(round2),
        .o_snake(snake2), .o_busy(busy2), .o_done(done2)
    );

    typedef struct {
        bit       rst, start, abort;
        bit [8:0] exp;   // {phase, step_en, odd, round, snake, busy, done}
    } vec_t;

    vec_t vecs[$];

`ifdef NANCI_SNAKE_EN
    localparam bit SNAKE_ON = 1'b1;
`else
    localparam bit SNAKE_ON = 1'b0;
`endif

    // Expected outputs k clocks after the start edge for the default build (k<0: idle).
    function automatic vec_t mk(bit r, bit s, bit a, int k);
        vec_t v;
        bit [1:0] ph;
        bit [1:0] rd;
        bit se, od, sn, bz, dn;
        int p;
        ph = 2'b00; rd = 2'b00; se = 0; od = 0; sn = 0; bz = 0; dn = 0;
        if (k >= 0 && k < 20) begin
            p  = k / 4;
            ph = (p % 2 == 0) ? 2'b01 : 2'b10;
            se = 1'b1;
            od = ((k % 4) % 2) == 1;
            rd = 2'(p / 2);
            sn = SNAKE_ON && (ph == 2'b01);
            bz = 1'b1;
        end else if (k == 20) begin
            ph = 2'b11;
            rd = 2'd2;
            bz = 1'b1;
        end else if (k == 21) begin
            dn = 1'b1;
        end
        v.rst = r; v.start = s; v.abort = a;
        v.exp = {ph, se, od, rd, sn, bz, dn};
        return v;
    endfunction

    initial begin
        bit [8:0] act;
        int busy_cnt, pulse_cnt, done_cnt, snake_cnt, since_pulse;
        bit timing_ok, odd_ok;

        rst = 1'b1; start = 1'b0; abort = 1'b0; start2 = 1'b0;

        // reset, idle, abort-in-idle, start+abort together
        vecs.push_back(mk(1, 0, 0, -1));
        vecs.push_back(mk(0, 0, 0, -1));
        vecs.push_back(mk(0, 0, 1, -1));
        vecs.push_back(mk(0, 1, 1, -1));
        // full run; start while busy and during DONE is ignored
        vecs.push_back(mk(0, 1, 0, 0));
        for (int k = 1; k <= 21; k++) vecs.push_back(mk(0, (k == 5 || k == 20), 0, k));
        vecs.push_back(mk(0, 1, 1, -1));
        vecs.push_back(mk(0, 0, 0, -1));
        // abort in the second clock of the first COL phase
        vecs.push_back(mk(0, 1, 0, 0));
        for (int k = 1; k <= 5; k++) vecs.push_back(mk(0, 0, 0, k));
        vecs.push_back(mk(0, 0, 1, -1));
        vecs.push_back(mk(0, 0, 0, -1));
        // full run after the abort
        vecs.push_back(mk(0, 1, 0, 0));
        for (int k = 1; k <= 21; k++) vecs.push_back(mk(0, 0, 0, k));
        vecs.push_back(mk(0, 0, 0, -1));
        // reset during COMPUTE wins over start, then a fresh run from round 0
        vecs.push_back(mk(0, 1, 0, 0));
        for (int k = 1; k <= 20; k++) vecs.push_back(mk(0, 0, 0, k));
        vecs.push_back(mk(1, 1, 0, -1));
        vecs.push_back(mk(0, 0, 0, -1));
        vecs.push_back(mk(0, 1, 0, 0));
        for (int k = 1; k <= 5; k++) vecs.push_back(mk(0, 0, 0, k));
        vecs.push_back(mk(1, 0, 0, -1));

        snake_cnt = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; start = vecs[i].start; abort = vecs[i].abort;
            @(posedge clk);
            #1;
            act = {phase, step_en, odd, round, snake, busy, done};
            if (i >= 4 && i <= 26 && snake) snake_cnt++;
            checks++;
            if (act !== vecs[i].exp) begin
                failures++;
                $display("FAIL vec%0d outputs actual=%b required=%b", i, act, vecs[i].exp);
            end
        end
        checks++;
        if (snake_cnt != (SNAKE_ON ? 12 : 0)) begin
            failures++;
            $display("FAIL snake_count actual=%0d required=%0d", snake_cnt, SNAKE_ON ? 12 : 0);
        end

        // SORT_CYCLES=3, ROUNDS=1 instance: 3 phases x 4 steps x 3 clocks + 1 compute
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        busy_cnt = 0; pulse_cnt = 0; done_cnt = 0; since_pulse = 0;
        timing_ok = 1'b1; odd_ok = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (busy2) busy_cnt++;
            if (done2) done_cnt++;
            if (step_en2) begin
                if (pulse_cnt != 0 && since_pulse != 3) timing_ok = 1'b0;
                if (odd2 != ((pulse_cnt % 4) % 2 == 1)) odd_ok = 1'b0;
                if (phase2 != (((pulse_cnt / 4) % 2 == 0) ? 2'b01 : 2'b10)) timing_ok = 1'b0;
                pulse_cnt++;
                since_pulse = 0;
            end
            since_pulse++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (busy_cnt != 37) begin
            failures++;
            $display("FAIL sc3_busy_clocks actual=%0d required=37", busy_cnt);
        end
        checks++;
        if (pulse_cnt != 12) begin
            failures++;
            $display("FAIL sc3_step_pulses actual=%0d required=12", pulse_cnt);
        end
        checks++;
        if (!timing_ok) begin
            failures++;
            $display("FAIL sc3_pulse_spacing actual=irregular required=every_3rd_clock");
        end
        checks++;
        if (!odd_ok) begin
            failures++;
            $display("FAIL sc3_odd_sequence actual=wrong required=0,1,0,1");
        end
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL sc3_done_pulses actual=%0d required=1", done_cnt);
        end
        checks++;
        if ({phase2, busy2, done2} !== 4'b0000) begin
            failures++;
            $display("FAIL sc3_final_idle actual=%b required=0000", {phase2, busy2, done2});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nanci_phase_ctrl.md
NANCI_PHASE_CTRL -- requirements
Module: nanci_phase_ctrl

Interface
REQ-001 SHALL have parameter SQRT_N, default 4: mesh side length; odd-even transposition steps per sort phase; >=2.
REQ-002 SHALL have parameter ROUNDS, default 2: row/column phase pairs before the final row phase; >=1.
REQ-003 SHALL have parameter SORT_CYCLES, default 1: clocks per transposition step; >=1.
REQ-004 SHALL have parameter COMPUTE_CYCLES, default 1: clocks in the compute phase; >=1.
REQ-005 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-007 SHALL have port i_start  input  1: start request, sampled in IDLE only.
REQ-008 SHALL have port i_abort  input  1: abandon the current sequence.
REQ-009 SHALL have port o_phase  output  2: 00 idle/done, 01 row sort, 10 column sort, 11 compute.
REQ-010 SHALL have port o_step_en  output  1: one-cycle pulse on the first clock of each transposition step.
REQ-011 SHALL have port o_odd  output  1: parity of the current step index (0 = even compare pairs).
REQ-012 SHALL have port o_round  output  ceil(log2(ROUNDS+1)): index of the current row/column pair.
REQ-013 SHALL have port o_snake  output  1: row-direction reversal enable for odd rows.
REQ-014 SHALL have port o_busy  output  1: high in ROW, COL and COMPUTE.
REQ-015 SHALL have port o_done  output  1: one-cycle completion pulse.

Function
REQ-016 SHALL implement the states IDLE, ROW, COL, COMPUTE and DONE.
REQ-017 IDLE with i_start=1 and i_abort=0 SHALL enter ROW on the next clock, with step=0, o_round=0, o_step_en=1 and o_odd=0.
REQ-018 Each step SHALL last SORT_CYCLES clocks; o_step_en SHALL be high only on the first of these clocks; the step counter SHALL count 0..SQRT_N-1.
REQ-019 After step SQRT_N-1 completes, ROW SHALL go to COL if o_round<ROUNDS, otherwise to COMPUTE; COL SHALL go to ROW and increment o_round; each new phase SHALL restart at step 0.
REQ-020 The sequence SHALL be (ROW,COL) x ROUNDS, then ROW, then COMPUTE; COMPUTE SHALL last COMPUTE_CYCLES clocks, with o_step_en=0 and o_odd=0.
REQ-021 COMPUTE SHALL go to DONE; DONE SHALL assert o_done for exactly one clock and then return to IDLE.
REQ-022 The busy duration SHALL be exactly (2*ROUNDS+1)*SQRT_N*SORT_CYCLES + COMPUTE_CYCLES clocks.
REQ-023 i_start SHALL be ignored in every state other than IDLE, including DONE.
REQ-024 i_abort=1 in ROW, COL or COMPUTE SHALL return to IDLE on the next clock with no o_done pulse; i_abort SHALL be ignored in IDLE and DONE.
REQ-025 i_start=1 and i_abort=1 together in IDLE SHALL leave the block in IDLE.
REQ-026 All outputs SHALL be registered; in IDLE, o_phase, o_step_en, o_odd, o_round, o_snake, o_busy and o_done SHALL all be 0.

Reset
REQ-027 rst=1 SHALL force IDLE and clear all counters and outputs to 0 on the next clock edge, regardless of state, and SHALL take priority over i_start and i_abort.
REQ-028 Reset in the middle of a phase SHALL produce no o_done pulse; the next i_start SHALL begin a full sequence from round 0.

Configuration
REQ-029 Macro NANCI_SNAKE_EN defined: o_snake SHALL equal 1 during ROW and 0 in every other state.
REQ-030 Macro NANCI_SNAKE_EN undefined: o_snake SHALL be tied to 0; all other behaviour SHALL be unchanged.

Verification
REQ-031 Defaults, i_start pulsed at cycle 0 -> o_busy high for 21 clocks; phase order 01x4, 10x4, 01x4, 10x4, 01x4, 11x1; then o_done=1 for 1 clock; then IDLE.
REQ-032 SORT_CYCLES=3, SQRT_N=4, ROUNDS=1 -> o_step_en pulses every 3rd clock with 12 pulses in total; o_odd sequence 0,1,0,1 in each phase; 37 busy clocks.
REQ-033 i_abort asserted in the 2nd clock of the first COL phase -> IDLE and all outputs 0 on the next clock; no o_done pulse; a following i_start produces a full 21-clock sequence.
REQ-034 rst asserted during COMPUTE -> all outputs 0 on the next clock; i_start pulsed during DONE or busy -> no effect; i_start and i_abort high together in IDLE -> block stays in IDLE.
REQ-035 Build with NANCI_SNAKE_EN and without it under defaults -> o_snake high for exactly 12 clocks when defined and 0 throughout when undefined; all other outputs identical between the two builds.
